// File: rtl/fft_peak_analyzer.sv
// Scans a captured 16-bin complex FFT frame one bin per cycle and reports the peak-magnitude bin index.
// Optional FFT_PEAK_MAG_OUT_EN adds a registered peak_mag output carrying the winning magnitude.
module fft_peak_analyzer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        busy,
  output logic        done,
  output logic [3:0]  freq
`ifdef FFT_PEAK_MAG_OUT_EN
  ,
  output logic [31:0] peak_mag
`endif
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e      state_q, state_d;
  logic [31:0] bank_q [16];
  logic [31:0] frameIn [16];
  logic [3:0]  binCnt_q, binCnt_d;
  logic [31:0] maxMag_q, maxMag_d;
  logic [3:0]  maxIdx_q, maxIdx_d;
  logic [3:0]  freq_q, freq_d;
  logic        done_q, done_d;
`ifdef FFT_PEAK_MAG_OUT_EN
  logic [31:0] peakMag_q, peakMag_d;
`endif

  logic               loadFrame, lastBin, takeBin;
  logic [31:0]        curWord, curMag, newMag;
  logic signed [15:0] curRe, curIm;
  logic signed [31:0] reSq, imSq;
  logic [3:0]         newIdx;

  assign frameIn[0]  = fft_d0;
  assign frameIn[1]  = fft_d1;
  assign frameIn[2]  = fft_d2;
  assign frameIn[3]  = fft_d3;
  assign frameIn[4]  = fft_d4;
  assign frameIn[5]  = fft_d5;
  assign frameIn[6]  = fft_d6;
  assign frameIn[7]  = fft_d7;
  assign frameIn[8]  = fft_d8;
  assign frameIn[9]  = fft_d9;
  assign frameIn[10] = fft_d10;
  assign frameIn[11] = fft_d11;
  assign frameIn[12] = fft_d12;
  assign frameIn[13] = fft_d13;
  assign frameIn[14] = fft_d14;
  assign frameIn[15] = fft_d15;

  assign loadFrame = (state_q == IDLE) && fft_valid;
  assign lastBin   = (state_q == SCAN) && (binCnt_q == 4'd15);

  // Each square fits in 31 bits, so the unsigned 32-bit sum tops out at exactly 2^31.
  assign curWord = bank_q[binCnt_q];
  assign curRe   = curWord[31:16];
  assign curIm   = curWord[15:0];
  assign reSq    = curRe * curRe;
  assign imSq    = curIm * curIm;
  assign curMag  = $unsigned(reSq) + $unsigned(imSq);

  // Bin 0 seeds the running max; strict compare afterwards keeps the lowest index on ties.
  assign takeBin = (binCnt_q == 4'd0) || (curMag > maxMag_q);
  assign newMag  = takeBin ? curMag : maxMag_q;
  assign newIdx  = takeBin ? binCnt_q : maxIdx_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fft_valid) state_d = SCAN;
      SCAN:    if (lastBin)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
    done = done_q;
    freq = freq_q;
`ifdef FFT_PEAK_MAG_OUT_EN
    peak_mag = peakMag_q;
`endif
  end

  // The bank is always overwritten before it is read, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (loadFrame) begin
      for (int k = 0; k < 16; k++) bank_q[k] <= frameIn[k];
    end
  end

  always_comb begin
    binCnt_d = binCnt_q;
    maxMag_d = maxMag_q;
    maxIdx_d = maxIdx_q;
    freq_d   = freq_q;
    done_d   = 1'b0;
`ifdef FFT_PEAK_MAG_OUT_EN
    peakMag_d = peakMag_q;
`endif
    if (loadFrame) begin
      binCnt_d = 4'd0;
    end else if (state_q == SCAN) begin
      binCnt_d = binCnt_q + 4'd1;
      maxMag_d = newMag;
      maxIdx_d = newIdx;
      if (lastBin) begin
        freq_d = newIdx;
        done_d = 1'b1;
`ifdef FFT_PEAK_MAG_OUT_EN
        peakMag_d = newMag;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      binCnt_q  <= 4'd0;
      maxMag_q  <= 32'd0;
      maxIdx_q  <= 4'd0;
      freq_q    <= 4'd0;
      done_q    <= 1'b0;
`ifdef FFT_PEAK_MAG_OUT_EN
      peakMag_q <= 32'd0;
`endif
    end else begin
      binCnt_q  <= binCnt_d;
      maxMag_q  <= maxMag_d;
      maxIdx_q  <= maxIdx_d;
      freq_q    <= freq_d;
      done_q    <= done_d;
`ifdef FFT_PEAK_MAG_OUT_EN
      peakMag_q <= peakMag_d;
`endif
    end
  end

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Self-checking bench for fft_peak_analyzer: directed corner frames plus random frames
// compared against an argmax-of-magnitude reference model.
module tb_fft_peak_analyzer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] dIn [16];
  logic        busy, done;
  logic [3:0]  freq;
`ifdef FFT_PEAK_MAG_OUT_EN
  logic [31:0] peak_mag;
`endif

  logic [31:0] frameBuf [16];
  logic [31:0] frameB [16];
  logic [3:0]  expFreq = 4'd0;
  int          testsRun = 0;
  int          testsFailed = 0;

  always #5 CLK = ~CLK;

  fft_peak_analyzer dut (
    .CLK(CLK), .RST(RST), .fft_valid(fft_valid),
    .fft_d0(dIn[0]),   .fft_d1(dIn[1]),   .fft_d2(dIn[2]),   .fft_d3(dIn[3]),
    .fft_d4(dIn[4]),   .fft_d5(dIn[5]),   .fft_d6(dIn[6]),   .fft_d7(dIn[7]),
    .fft_d8(dIn[8]),   .fft_d9(dIn[9]),   .fft_d10(dIn[10]), .fft_d11(dIn[11]),
    .fft_d12(dIn[12]), .fft_d13(dIn[13]), .fft_d14(dIn[14]), .fft_d15(dIn[15]),
    .busy(busy), .done(done), .freq(freq)
`ifdef FFT_PEAK_MAG_OUT_EN
    , .peak_mag(peak_mag)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: magnitude per bin with plain integer arithmetic, first occurrence of the maximum wins.
  task automatic refModel(output logic [3:0] idx, output longint mag);
    longint best;
    best = -1;
    idx  = 4'd0;
    for (int k = 0; k < 16; k++) begin
      longint re, im, m;
      re = longint'($signed(frameBuf[k][31:16]));
      im = longint'($signed(frameBuf[k][15:0]));
      m  = re * re + im * im;
      if (m > best) begin
        best = m;
        idx  = 4'(k);
      end
    end
    mag = best;
  endtask

  task automatic fillFrame(input logic [31:0] value);
    for (int k = 0; k < 16; k++) frameBuf[k] = value;
  endtask

  // Called just after a falling edge; returns just after the falling edge following E17.
  task automatic applyStimulus(input string tag);
    logic [3:0] expIdx;
    longint     expMag;
    int         earlyDone, busyLow;
    earlyDone = 0;
    busyLow   = 0;
    refModel(expIdx, expMag);
    for (int k = 0; k < 16; k++) dIn[k] = frameBuf[k];
    fft_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    fft_valid = 1'b0;
    checkOutput({tag, ".busyAfterE0"}, 64'(busy), 64'd1);
    checkOutput({tag, ".freqHeldAtLoad"}, 64'(freq), 64'(expFreq));
    for (int c = 1; c <= 15; c++) begin
      @(posedge CLK); @(negedge CLK);
      if (done) earlyDone++;
      if (!busy) busyLow++;
    end
    checkOutput({tag, ".earlyDone"}, 64'(earlyDone), 64'd0);
    checkOutput({tag, ".busyDropouts"}, 64'(busyLow), 64'd0);
    @(posedge CLK); @(negedge CLK);
    checkOutput({tag, ".doneAfterE16"}, 64'(done), 64'd1);
    checkOutput({tag, ".busyAfterE16"}, 64'(busy), 64'd0);
    checkOutput({tag, ".freq"}, 64'(freq), 64'(expIdx));
`ifdef FFT_PEAK_MAG_OUT_EN
    checkOutput({tag, ".peakMag"}, 64'(peak_mag), 64'(expMag[31:0]));
`endif
    expFreq = expIdx;
    @(posedge CLK); @(negedge CLK);
    checkOutput({tag, ".doneAfterE17"}, 64'(done), 64'd0);
    checkOutput({tag, ".freqHold"}, 64'(freq), 64'(expFreq));
  endtask

  task automatic countDones(input int cycles, output int n, output logic [3:0] freqAtDone);
    n = 0;
    freqAtDone = 4'hF;
    for (int c = 0; c < cycles; c++) begin
      @(posedge CLK); @(negedge CLK);
      if (done) begin
        n++;
        freqAtDone = freq;
      end
    end
  endtask

  task automatic randomFrame();
    logic [15:0] ext [4];
    int mode;
    ext[0] = 16'h8000; ext[1] = 16'h7FFF; ext[2] = 16'h8001; ext[3] = 16'h0000;
    mode = int'($urandom_range(0, 2));
    for (int k = 0; k < 16; k++) begin
      int r, i;
      case (mode)
        0: frameBuf[k] = $urandom;
        1: begin
          r = int'($urandom_range(0, 6)) - 3;
          i = int'($urandom_range(0, 6)) - 3;
          frameBuf[k] = {16'(r), 16'(i)};
        end
        default: frameBuf[k] = {ext[$urandom_range(0, 3)], ext[$urandom_range(0, 3)]};
      endcase
    end
  endtask

  initial begin
    int nDone;
    logic [3:0] fDone;
    for (int k = 0; k < 16; k++) dIn[k] = 32'd0;

    #3 RST = 1'b0;
    #1;
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.freq", 64'(freq), 64'd0);
`ifdef FFT_PEAK_MAG_OUT_EN
    checkOutput("reset.peakMag", 64'(peak_mag), 64'd0);
`endif
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;

    fillFrame(32'd0);
    frameBuf[5] = {16'sd100, 16'sd0};
    applyStimulus("singlePeak");
    checkOutput("singlePeak.freqConst", 64'(freq), 64'd5);
`ifdef FFT_PEAK_MAG_OUT_EN
    checkOutput("singlePeak.magConst", 64'(peak_mag), 64'd10000);
`endif

    fillFrame(32'd0);
    applyStimulus("allZero");
    checkOutput("allZero.freqConst", 64'(freq), 64'd0);

    fillFrame({16'sd1, 16'sd1});
    frameBuf[3] = {16'sd30, 16'sd40};
    frameBuf[9] = {16'sd30, 16'sd40};
    applyStimulus("tie");
    checkOutput("tie.freqConst", 64'(freq), 64'd3);

    fillFrame(32'd0);
    frameBuf[15] = {16'h8000, 16'h8000};
    frameBuf[0]  = {16'h7FFF, 16'h7FFF};
    applyStimulus("extreme");
    checkOutput("extreme.freqConst", 64'(freq), 64'd15);
`ifdef FFT_PEAK_MAG_OUT_EN
    checkOutput("extreme.magConst", 64'(peak_mag), 64'h80000000);
`endif

    for (int n = 0; n < 20; n++) begin
      randomFrame();
      applyStimulus($sformatf("random%0d", n));
    end

    // Frame B arrives at E8 while A is still scanning and must be dropped.
    fillFrame({16'sd2, 16'sd2});
    frameBuf[2] = {16'sd50, -16'sd50};
    for (int k = 0; k < 16; k++) dIn[k] = frameBuf[k];
    fft_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    fft_valid = 1'b0;
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 16; k++) dIn[k] = {16'sd3, 16'sd3};
    dIn[12] = {16'sd900, 16'sd900};
    fft_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    fft_valid = 1'b0;
    countDones(30, nDone, fDone);
    checkOutput("busyValid.doneCount", 64'(nDone), 64'd1);
    checkOutput("busyValid.freq", 64'(fDone), 64'd2);
    checkOutput("busyValid.freqAfter", 64'(freq), 64'd2);
    checkOutput("busyValid.idle", 64'(busy), 64'd0);
    expFreq = 4'd2;

    // Back-to-back: fft_valid held high from E0 through E17.
    fillFrame({16'sd1, 16'sd1});
    frameBuf[7] = {16'sd200, -16'sd5};
    for (int k = 0; k < 16; k++) frameB[k] = {-16'sd4, 16'sd4};
    frameB[1] = {-16'sd300, 16'sd10};
    for (int k = 0; k < 16; k++) dIn[k] = frameBuf[k];
    fft_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    for (int k = 0; k < 16; k++) dIn[k] = frameB[k];
    countDones(15, nDone, fDone);
    checkOutput("b2b.earlyDoneA", 64'(nDone), 64'd0);
    @(posedge CLK); @(negedge CLK);
    checkOutput("b2b.doneA", 64'(done), 64'd1);
    checkOutput("b2b.freqA", 64'(freq), 64'd7);
    @(posedge CLK); @(negedge CLK);
    fft_valid = 1'b0;
    checkOutput("b2b.doneAfterE17", 64'(done), 64'd0);
    checkOutput("b2b.busyB", 64'(busy), 64'd1);
    countDones(15, nDone, fDone);
    checkOutput("b2b.earlyDoneB", 64'(nDone), 64'd0);
    @(posedge CLK); @(negedge CLK);
    checkOutput("b2b.doneB", 64'(done), 64'd1);
    checkOutput("b2b.freqB", 64'(freq), 64'd1);
    @(posedge CLK); @(negedge CLK);
    checkOutput("b2b.doneEnd", 64'(done), 64'd0);
    expFreq = 4'd1;

    // Reset asserted just after E10 of a frame aborts it.
    randomFrame();
    for (int k = 0; k < 16; k++) dIn[k] = frameBuf[k];
    fft_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    fft_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    checkOutput("midReset.busy", 64'(busy), 64'd0);
    checkOutput("midReset.freq", 64'(freq), 64'd0);
    checkOutput("midReset.done", 64'(done), 64'd0);
    countDones(2, nDone, fDone);
    checkOutput("midReset.noDone", 64'(nDone), 64'd0);
    RST = 1'b1;
    expFreq = 4'd0;
    fillFrame(32'd0);
    frameBuf[11] = {-16'sd7, 16'sd9};
    applyStimulus("afterReset");
    checkOutput("afterReset.freqConst", 64'(freq), 64'd11);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fft_peak_analyzer.md
FFT_PEAK_ANALYZER -- requirements
Module: fft_peak_analyzer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port fft_valid, input, 1 bit: frame strobe; fft_d0..fft_d15 are valid in that cycle.
REQ-004 SHALL have ports fft_d0..fft_d15, input, 32 bits each: bin k = {re[31:16], im[15:0]}, both signed two's complement.
REQ-005 SHALL have port busy, output, 1 bit: high while a frame is being scanned.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse; freq is valid for the new frame.
REQ-007 SHALL have port freq, output, 4 bits: index of the peak-magnitude bin.

Function
REQ-008 SHALL be in state IDLE or SCAN; busy = (state == SCAN).
REQ-009 SHALL, in IDLE with fft_valid=1 at a rising edge, capture all 16 words into an internal bank, clear the bin counter to 0, and enter SCAN.
REQ-010 SHALL ignore fft_valid while in SCAN: no capture, no bank change, no error indication.
REQ-011 SHALL, in SCAN, process exactly one bin per edge in order 0..15, indexed by the bin counter.
REQ-012 SHALL compute mag = re*re + im*im as a 32-bit unsigned value with no truncation; the maximum is 2^31 when re = im = -32768.
REQ-013 SHALL load bin 0 unconditionally as the running max and index.
REQ-014 SHALL replace the running max and index for bins 1..15 only when mag > running max; ties keep the lower index.
REQ-015 SHALL, on the edge that processes bin 15, register freq with the final index, pulse done, and return to IDLE.
REQ-016 SHALL meet this latency: fft_valid sampled at edge E0 gives done=1 in the cycle after edge E16.
REQ-017 SHALL deassert done at edge E17.
REQ-018 SHALL accept a new frame at E17 if fft_valid=1, giving a throughput of one frame per 17 cycles.
REQ-019 SHALL hold freq at its last value between done pulses.
REQ-020 SHALL NOT update freq when the bank is loaded.
REQ-021 SHALL report freq = 0 with done for an all-zero frame.

Reset
REQ-022 SHALL, when RST=0, immediately force state=IDLE, busy=0, done=0, freq=0, bin counter=0, running max=0 and running index=0, independent of CLK.
REQ-023 SHALL leave the capture bank contents unspecified under reset, since it is always overwritten before use.
REQ-024 SHALL abort a scan if reset asserts mid-SCAN: no done pulse for that frame, and freq reads 0 after reset.
REQ-025 SHALL accept fft_valid on the first rising edge after RST deasserts.

Configuration
REQ-026 SHALL, when macro FFT_PEAK_MAG_OUT_EN is defined, add output port peak_mag (32 bits), registered with freq at the bin-15 edge and holding the winning mag.
REQ-027 SHALL reset peak_mag to 0 when FFT_PEAK_MAG_OUT_EN is defined.
REQ-028 SHALL, without FFT_PEAK_MAG_OUT_EN, have no peak_mag port, with all other behaviour identical.

Verification
REQ-029 SHALL cover a single peak: bin 5 = {16'sd100, 16'sd0}, all others 0, fft_valid pulsed at E0 -> busy=1 from E0 to E16, done=1 for one cycle after E16, freq=5 (peak_mag=10000 with the macro).
REQ-030 SHALL cover a tie: bins 3 and 9 both {16'sd30, 16'sd40} (mag 2500), others {1,1} -> freq=3.
REQ-031 SHALL cover extreme values: bin 15 = {16'h8000, 16'h8000}, bin 0 = {16'h7FFF, 16'h7FFF} -> freq=15, peak_mag=32'h80000000 (no overflow).
REQ-032 SHALL cover fft_valid while busy: frame A with peak at bin 2, then at E8 frame B with peak at bin 12 -> done once with freq=2; frame B dropped.
REQ-033 SHALL cover back-to-back frames: frame A (peak bin 7), then frame B (peak bin 1) with fft_valid held high from E0 through E17 -> done after E16 with freq=7 and after E33 with freq=1.
REQ-034 SHALL cover reset mid-scan: RST=0 for 2 cycles at E10 of a frame -> busy=0 and freq=0 immediately, no done; the next frame completes normally.
